// File: rtl/ram_loader_pkg.sv
// Shared state encodings and defaults for the scratch-RAM program loader.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam int unsigned WORDS_DEF = 16;

endpackage

// File: rtl/ram_loader_ram_port_mux.sv
// 2:1 selection of the RAM pin group between the CPU side and the loader registers.
module ram_port_mux #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              sel_ld,
  input  logic              cpu_cs_n,
  input  logic              cpu_we_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              ld_cs_n,
  input  logic              ld_we_n,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data
);

  assign ram_cs_n = sel_ld ? ld_cs_n : cpu_cs_n;
  assign ram_we_n = sel_ld ? ld_we_n : cpu_we_n;
  assign ram_addr = sel_ld ? ld_addr : cpu_addr;
  assign ram_data = sel_ld ? ld_data : cpu_data;

endmodule

// File: rtl/ram_loader.sv
// Program loader: streams host nibbles into consecutive RAM words with a
// registered CS/WE sequence; passes the CPU through to the RAM when idle.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int WORDS  = WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cpu_cs_n,
  input  logic              cpu_we_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              abort_q, abort_d;
  logic              cs_n_q, we_n_q, busy_q, done_q, rdy_q;

  // abort_q remembers a load_en drop seen mid-write so the word still
  // completes through HOLD even if load_en comes back before then.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: if (load_en) begin
        state_d = S_WAIT;
        ptr_d   = '0;
        abort_d = 1'b0;
      end
      S_WAIT: begin
        // A load_en drop wins over a simultaneous handshake.
        if (!load_en) state_d = S_IDLE;
        else if (in_valid && rdy_q) begin
          data_d  = in_data;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        if (!load_en) abort_d = 1'b1;
      end
      S_STROBE: begin
        state_d = S_HOLD;
        if (!load_en) abort_d = 1'b1;
      end
      S_HOLD: begin
        abort_d = 1'b0;
        if (abort_q || !load_en) state_d = S_IDLE;
        else if (ptr_q == LAST)  state_d = S_DONE;
        else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DONE:  if (!load_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin-level controls are decoded from the next state and registered, so
  // every loader-driven RAM output comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
      cs_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      cs_n_q  <= !(state_d inside {S_SETUP, S_STROBE, S_HOLD});
      we_n_q  <= (state_d != S_STROBE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      rdy_q   <= (state_d == S_WAIT);
    end
  end

  assign in_ready = rdy_q;
  assign busy     = busy_q;
  assign done     = done_q;

  ram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .sel_ld   (busy_q),
    .cpu_cs_n (cpu_cs_n),
    .cpu_we_n (cpu_we_n),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .ld_cs_n  (cs_n_q),
    .ld_we_n  (we_n_q),
    .ld_addr  (ptr_q),
    .ld_data  (data_q),
    .ram_cs_n (ram_cs_n),
    .ram_we_n (ram_we_n),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

endmodule
